wash_sequencer: RTL and testbench
=================================

# wash_sequencer

Phase controller for the washing machine: owns the BCD phase timer (`timer_counter`) and drives the water valves and motor. It runs fill → wash → drain → N×(fill → rinse → drain) → spin → done. For each phase it loads the timer preset, enables counting, and advances on the timer's terminal-count flag. It sits between the panel inputs (START/PAUSE/ABORT/MODE) and the timer/actuator outputs.

## Interface
- T_FILL, 8'h15, fill duration preset, 2-digit BCD
- T_WASH, 8'h31, wash duration preset, BCD
- T_RINSE, 8'h20, rinse agitation preset, BCD
- T_DRAIN, 8'h10, drain preset, BCD
- T_SPIN, 8'h25, spin preset, BCD
- CP  in  1  clock, rising edge
- CR  in  1  reset, asynchronous, active-low
- START  in  1  level; begins cycle from IDLE, acknowledges DONE
- PAUSE  in  1  level; freezes current phase
- ABORT  in  1  level; jumps to final drain
- MODE  in  2  rinse count: 0→1, 1→2, 2→3, 3→2
- QCC  in  1  timer terminal count (timer Q == 8'h00)
- RS  out  8  preset to timer
- LD  out  1  timer load strobe; timer takes RS on the edge ending an LD=1 cycle
- CE  out  1  timer count enable (BCD decrement)
- VALVE_IN, MOTOR_WASH, VALVE_OUT, MOTOR_SPIN  out  1 each  actuators
- PHASE  out  3  IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6
- RINSE_LEFT  out  2  rinses remaining
- DONE  out  1  high in DONE state

## Operation
- State register plus 2-bit rinse counter, a `first` flag (first cycle of a phase), and a `final` flag (current drain is the last one).
- IDLE: wait for START=1. Then capture MODE into RINSE_LEFT, clear `final`, and go to FILL.
- FILL: VALVE_IN=1. When done, go to WASH if RINSE_LEFT equals the captured count and no rinse has started; otherwise go to RINSE.
- WASH: MOTOR_WASH=1, preset T_WASH, then go to DRAIN.
- RINSE: MOTOR_WASH=1, preset T_RINSE. When done, decrement RINSE_LEFT and go to DRAIN.
- DRAIN: VALVE_OUT=1, preset T_DRAIN. When done:
  - `final`=1 → DONE
  - RINSE_LEFT≠0 → FILL
  - otherwise → SPIN
- SPIN: MOTOR_SPIN=1, VALVE_OUT=1, preset T_SPIN, then go to DONE.
- DONE: DONE=1, CE=0. Return to IDLE when START=0.
- A "rinse started" bit distinguishes the first fill (leads to WASH) from rinse fills (lead to RINSE).
- ABORT=1 in any phase state (FILL..SPIN, not DRAIN with `final`=1): next state is DRAIN with `final`=1, and the timer is reloaded. ABORT is ignored in IDLE and DONE.
- PAUSE=1 in a phase state: CE=0, all actuators 0, and state/flags/RINSE_LEFT are held. ABORT overrides PAUSE. PAUSE is ignored in IDLE and DONE.
- RS is held at the current phase preset. In IDLE and DONE, RS=8'h00.
- Presets must be valid BCD; no checking is done.

## Timing
- Reset (CR=0, async) gives: PHASE=IDLE, RS=8'h00, LD=0, CE=0, all actuators 0, DONE=0, RINSE_LEFT=0.
- Phase entry cycle t: LD=1, CE=0. QCC is ignored in this cycle, even if the old Q is 0.
- Cycles t+1 onward: CE=1 (unless paused). The transition occurs on the edge where CE=1 and QCC=1.
- Phase length is N+2 cycles, where N is the decimal value of the preset. Preset 8'h00 gives 2 cycles.
- PAUSE for P cycles lengthens the phase by exactly P. If PAUSE is high during the LD cycle, LD is still issued.
- Actuator outputs, PHASE and DONE are decoded from registered state only; there is no combinational path from inputs.
- START→FILL takes 1 cycle. ABORT→DRAIN takes 1 cycle, and LD is asserted in the DRAIN entry cycle.
- The CE=1 cycle at QCC may decrement the timer past 0. This is harmless because the next cycle reloads via LD.

## Test plan
- Reset mid-WASH (CR low for 3 cycles) → all outputs 0, PHASE=0, RS=8'h00 immediately (async).
- All presets 8'h02, MODE=0, START pulse:
  - PHASE sequence 1,2,3,1,4,3,5,6
  - each phase lasts 4 cycles
  - one LD pulse per phase
  - DONE stays high until START=0
- MODE=2 with default presets → three FILL/RINSE/DRAIN groups; RINSE_LEFT steps 3→2→1→0; FILL lasts 17 cycles.
- PAUSE held 5 cycles mid-FILL (T_FILL=8'h15) → VALVE_IN and CE low for those 5 cycles; FILL lasts 22 cycles.
- ABORT during SPIN → next cycle PHASE=3 with LD=1 and RS=8'h10. After 12 cycles PHASE=6; SPIN is not re-entered.
- QCC forced high during the LD cycle of FILL → no transition; FILL completes its full N+2 cycles.

Source files
------------

// File: rtl/wash_sequencer.sv
// wash_sequencer: washing-machine phase controller; sequences fill/wash/drain/rinse/spin
// by loading an external BCD timer per phase and advancing on its terminal count.
module wash_sequencer #(
    parameter logic [7:0] T_FILL  = 8'h15,
    parameter logic [7:0] T_WASH  = 8'h31,
    parameter logic [7:0] T_RINSE = 8'h20,
    parameter logic [7:0] T_DRAIN = 8'h10,
    parameter logic [7:0] T_SPIN  = 8'h25
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       START,
    input  logic       PAUSE,
    input  logic       ABORT,
    input  logic [1:0] MODE,
    input  logic       QCC,
    output logic [7:0] RS,
    output logic       LD,
    output logic       CE,
    output logic       VALVE_IN,
    output logic       MOTOR_WASH,
    output logic       VALVE_OUT,
    output logic       MOTOR_SPIN,
    output logic [2:0] PHASE,
    output logic [1:0] RINSE_LEFT,
    output logic       DONE
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_DRAIN = 3'd3,
        S_RINSE = 3'd4,
        S_SPIN  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t     state, state_n;
    logic [1:0] rinse_left, rinse_n;
    logic       first, first_n;
    logic       last_drain, last_n;
    logic       started, started_n;
    logic       paused, paused_n;
    logic       in_phase, next_in_phase, adv, abort_go;

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state      <= S_IDLE;
            rinse_left <= 2'd0;
            first      <= 1'b0;
            last_drain <= 1'b0;
            started    <= 1'b0;
            paused     <= 1'b0;
        end else begin
            state      <= state_n;
            rinse_left <= rinse_n;
            first      <= first_n;
            last_drain <= last_n;
            started    <= started_n;
            paused     <= paused_n;
        end
    end

    always_comb begin
        in_phase  = state != S_IDLE && state != S_DONE;
        CE        = in_phase && !first && !paused;
        adv       = CE && QCC;
        abort_go  = in_phase && ABORT && !(state == S_DRAIN && last_drain);
        state_n   = state;
        rinse_n   = rinse_left;
        last_n    = last_drain;
        started_n = started;
        case (state)
            S_IDLE: if (START) begin
                state_n   = S_FILL;
                rinse_n   = MODE == 2'd0 ? 2'd1 : MODE == 2'd2 ? 2'd3 : 2'd2;
                last_n    = 1'b0;
                started_n = 1'b0;
            end
            S_FILL:  if (adv) state_n = started ? S_RINSE : S_WASH;
            S_WASH: if (adv) begin
                state_n   = S_DRAIN;
                started_n = 1'b1;
            end
            S_RINSE: if (adv) begin
                state_n = S_DRAIN;
                rinse_n = rinse_left - 2'd1;
            end
            S_DRAIN: if (adv) state_n = last_drain ? S_DONE : rinse_left != 2'd0 ? S_FILL : S_SPIN;
            S_SPIN:  if (adv) state_n = S_DONE;
            S_DONE:  if (!START) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort_go) begin
            state_n = S_DRAIN;
            last_n  = 1'b1;
        end
        next_in_phase = state_n != S_IDLE && state_n != S_DONE;
        // An abort out of a non-final drain stays in DRAIN yet must still reload the timer.
        first_n  = abort_go || (state_n != state && next_in_phase);
        paused_n = PAUSE && !abort_go && next_in_phase;
        RS = state == S_FILL  ? T_FILL  :
             state == S_WASH  ? T_WASH  :
             state == S_DRAIN ? T_DRAIN :
             state == S_RINSE ? T_RINSE :
             state == S_SPIN  ? T_SPIN  : 8'h00;
        LD         = first;
        VALVE_IN   = state == S_FILL && !paused;
        MOTOR_WASH = (state == S_WASH || state == S_RINSE) && !paused;
        VALVE_OUT  = (state == S_DRAIN || state == S_SPIN) && !paused;
        MOTOR_SPIN = state == S_SPIN && !paused;
        PHASE      = state;
        RINSE_LEFT = rinse_left;
        DONE       = state == S_DONE;
    end
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed bench; two sequencers (short presets / default presets) each
// driving a behavioural BCD down-counter timer.
module tb_wash_sequencer;
    logic CP = 1'b0;
    logic CR = 1'b0;
    logic [1:0] start = '0, pause = '0, abort_in = '0, qcc_f = '0, qcc;
    logic [1:0][1:0] mode = '0;
    logic [1:0][7:0] rs, q;
    logic [1:0] ld, ce, vin, mw, vout, ms, done;
    logic [1:0][2:0] ph;
    logic [1:0][1:0] rl;
    int checks = 0, errors = 0;
    int seq[$], len[$], lds[$], rls[$];

    always #5 CP = ~CP;

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        return v == 8'h00 ? 8'h99 : v[3:0] == 4'h0 ? {v[7:4] - 4'd1, 4'h9} : v - 8'd1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : tmr
        always_ff @(posedge CP or negedge CR)
            if (!CR) q[g] <= 8'h00;
            else if (ld[g]) q[g] <= rs[g];
            else if (ce[g]) q[g] <= bcd_dec(q[g]);
        assign qcc[g] = (q[g] == 8'h00) | qcc_f[g];
    end

    wash_sequencer #(.T_FILL(8'h02), .T_WASH(8'h02), .T_RINSE(8'h02), .T_DRAIN(8'h02), .T_SPIN(8'h02)) dut_a (
        .CP(CP), .CR(CR), .START(start[0]), .PAUSE(pause[0]), .ABORT(abort_in[0]), .MODE(mode[0]),
        .QCC(qcc[0]), .RS(rs[0]), .LD(ld[0]), .CE(ce[0]), .VALVE_IN(vin[0]), .MOTOR_WASH(mw[0]),
        .VALVE_OUT(vout[0]), .MOTOR_SPIN(ms[0]), .PHASE(ph[0]), .RINSE_LEFT(rl[0]), .DONE(done[0]));

    wash_sequencer dut_b (
        .CP(CP), .CR(CR), .START(start[1]), .PAUSE(pause[1]), .ABORT(abort_in[1]), .MODE(mode[1]),
        .QCC(qcc[1]), .RS(rs[1]), .LD(ld[1]), .CE(ce[1]), .VALVE_IN(vin[1]), .MOTOR_WASH(mw[1]),
        .VALVE_OUT(vout[1]), .MOTOR_SPIN(ms[1]), .PHASE(ph[1]), .RINSE_LEFT(rl[1]), .DONE(done[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs(input int d);
        return {ph[d], rs[d], ld[d], ce[d], vin[d], mw[d], vout[d], ms[d], done[d], rl[d]};
    endfunction

    task automatic trace(input int d, input int lim);
        logic [2:0] last;
        last = 3'd7;
        seq = {}; len = {}; lds = {}; rls = {};
        for (int k = 0; k < lim; k++) begin
            @(negedge CP);
            if (ph[d] != last) begin
                seq.push_back(int'(ph[d])); len.push_back(0); lds.push_back(0); rls.push_back(int'(rl[d]));
                last = ph[d];
            end
            len[len.size() - 1] += 1;
            if (ld[d]) lds[lds.size() - 1] += 1;
            if (ph[d] == 3'd6) return;
        end
        chk("trace_timeout", 32'(ph[d]), 32'd6);
    endtask

    int exp_a[8] = '{1, 2, 3, 1, 4, 3, 5, 6};
    int exp_bs[14] = '{1, 2, 3, 1, 4, 3, 1, 4, 3, 1, 4, 3, 5, 6};
    int exp_bl[13] = '{17, 33, 12, 17, 22, 12, 17, 22, 12, 17, 22, 12, 27};
    int exp_br[14] = '{3, 3, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0};

    initial begin
        int fill_len, vlow, celow, n;
        logic spin_seen;
        repeat (2) @(negedge CP);
        chk("reset_a", outs(0), 0);
        chk("reset_b", outs(1), 0);
        CR = 1'b1;
        @(negedge CP);

        // short presets, single rinse; START held so DONE persists
        mode[0] = 2'd0;
        start[0] = 1'b1;
        trace(0, 200);
        chk("a_nphases", seq.size(), 8);
        for (int i = 0; i < 8 && i < seq.size(); i++) begin
            chk($sformatf("a_phase%0d", i), seq[i], exp_a[i]);
            if (i < 7) begin
                chk($sformatf("a_len%0d", i), len[i], 4);
                chk($sformatf("a_ld%0d", i), lds[i], 1);
            end
        end
        repeat (3) @(negedge CP);
        chk("a_done_held", {done[0], ce[0], ph[0]}, {1'b1, 1'b0, 3'd6});
        start[0] = 1'b0;
        @(negedge CP);
        chk("a_back_idle", {done[0], ph[0]}, {1'b0, 3'd0});

        // default presets, three rinses
        mode[1] = 2'd2;
        start[1] = 1'b1;
        trace(1, 1000);
        chk("b_nphases", seq.size(), 14);
        for (int i = 0; i < 14 && i < seq.size(); i++) begin
            chk($sformatf("b_phase%0d", i), seq[i], exp_bs[i]);
            chk($sformatf("b_rl%0d", i), rls[i], exp_br[i]);
            if (i < 13) chk($sformatf("b_len%0d", i), len[i], exp_bl[i]);
        end
        start[1] = 1'b0;
        @(negedge CP);
        chk("b_back_idle", 32'(ph[1]), 32'd0);

        // pause for 5 cycles inside FILL
        mode[1] = 2'd0;
        start[1] = 1'b1;
        @(negedge CP);
        chk("p_entry", {ph[1], ld[1], ce[1], rl[1]}, {3'd1, 1'b1, 1'b0, 2'd1});
        start[1] = 1'b0;
        fill_len = 1; vlow = 0; celow = 1;
        for (int k = 1; k < 100; k++) begin
            if (k == 5) pause[1] = 1'b1;
            if (k == 10) pause[1] = 1'b0;
            @(negedge CP);
            if (ph[1] != 3'd1) break;
            fill_len++;
            if (!vin[1]) vlow++;
            if (!ce[1]) celow++;
        end
        chk("p_fill_len", fill_len, 22);
        chk("p_valve_low", vlow, 5);
        chk("p_ce_low", celow, 6);
        chk("p_next_wash", 32'(ph[1]), 32'd2);

        // abort during SPIN
        n = 0;
        while (ph[1] != 3'd5 && n < 400) begin
            @(negedge CP);
            n++;
        end
        chk("ab_reach_spin", 32'(ph[1]), 32'd5);
        repeat (3) @(negedge CP);
        chk("ab_spin_out", {ms[1], vout[1], ce[1]}, 3'b111);
        abort_in[1] = 1'b1;
        @(negedge CP);
        abort_in[1] = 1'b0;
        chk("ab_drain", {ph[1], ld[1], rs[1], vout[1]}, {3'd3, 1'b1, 8'h10, 1'b1});
        spin_seen = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CP);
            if (ph[1] == 3'd5) spin_seen = 1'b1;
            if (c == 11) chk("ab_still_drain", 32'(ph[1]), 32'd3);
        end
        chk("ab_done", {ph[1], done[1]}, {3'd6, 1'b1});
        chk("ab_no_spin", 32'(spin_seen), 32'd0);
        @(negedge CP);
        chk("ab_idle", 32'(ph[1]), 32'd0);

        // terminal count forced during FILL load cycle must be ignored
        start[1] = 1'b1;
        @(negedge CP);
        chk("q_entry", {ph[1], ld[1]}, {3'd1, 1'b1});
        qcc_f[1] = 1'b1;
        start[1] = 1'b0;
        @(negedge CP);
        qcc_f[1] = 1'b0;
        fill_len = 1;
        for (int k = 0; k < 100 && ph[1] == 3'd1; k++) begin
            fill_len++;
            @(negedge CP);
        end
        chk("q_fill_len", fill_len, 17);
        chk("q_next_wash", 32'(ph[1]), 32'd2);

        // async reset mid-WASH
        repeat (5) @(negedge CP);
        chk("r_in_wash", {ph[1], mw[1], rs[1]}, {3'd2, 1'b1, 8'h31});
        #2 CR = 1'b0;
        #1 chk("r_async", outs(1), 0);
        repeat (3) @(negedge CP);
        chk("r_held", outs(1), 0);
        CR = 1'b1;
        @(negedge CP);
        chk("r_release_idle", outs(1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
